// File: rtl/lw_sha2_ctx_core.sv
// Word-serial SHA-2 compression core (SHA-224/256 or SHA-384/512 family), one round per clock,
// with chaining-value save/restore and a held, backpressured digest output.
module lw_sha2_ctx_core #(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned CTX_EN    = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [1:0]             mode_i,
  input  logic                   ctx_load_i,
  input  logic [8*WORD_SIZE-1:0] ctx_i,
  input  logic                   data_valid_i,
  output logic                   data_ready_o,
  input  logic [WORD_SIZE-1:0]   data_i,
  input  logic                   last_i,
  input  logic                   abort_i,
  output logic                   busy_o,
  output logic                   err_o,
  output logic [8*WORD_SIZE-1:0] ctx_o,
  output logic                   ctx_valid_o,
  output logic [8*WORD_SIZE-1:0] hash_o,
  output logic                   hash_valid_o,
  input  logic                   hash_ready_i
);

  localparam int unsigned W      = WORD_SIZE;
  localparam int unsigned ROUNDS = (W == 64) ? 80 : 64;
  localparam logic [6:0]  LastRound = 7'(ROUNDS - 1);

  if (!(W == 32 || W == 64)) begin : g_bad_word_size
    $fatal(1, "lw_sha2_ctx_core: WORD_SIZE must be 32 or 64");
  end

  localparam int unsigned BS0A = (W == 32) ? 2  : 28;
  localparam int unsigned BS0B = (W == 32) ? 13 : 34;
  localparam int unsigned BS0C = (W == 32) ? 22 : 39;
  localparam int unsigned BS1A = (W == 32) ? 6  : 14;
  localparam int unsigned BS1B = (W == 32) ? 11 : 18;
  localparam int unsigned BS1C = (W == 32) ? 25 : 41;
  localparam int unsigned SS0A = (W == 32) ? 7  : 1;
  localparam int unsigned SS0B = (W == 32) ? 18 : 8;
  localparam int unsigned SS0C = (W == 32) ? 3  : 7;
  localparam int unsigned SS1A = (W == 32) ? 17 : 19;
  localparam int unsigned SS1B = (W == 32) ? 19 : 61;
  localparam int unsigned SS1C = (W == 32) ? 10 : 6;

  // SHA-256 round constants are the upper halves of the SHA-512 ones.
  localparam logic [63:0] K64 [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  // SHA-256 IV = upper halves of the SHA-512 IV; SHA-224 IV = lower halves of the SHA-384 IV.
  localparam logic [63:0] IV512 [8] = '{
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
  localparam logic [63:0] IV384 [8] = '{
    64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
    64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4};
  localparam logic [63:0] IV512_256 [8] = '{
    64'h22312194fc2bf72c, 64'h9f555fa3c84c64c2, 64'h2393b86b6f53b151, 64'h963877195940eabd,
    64'h96283ee2a88effe3, 64'hbe5e1e2553863992, 64'h2b0199fc2c85b8aa, 64'h0eb72ddc81c52ca2};
  localparam logic [63:0] IV512_224 [8] = '{
    64'h8c3d37c819544da2, 64'h73e1996689dcd4d6, 64'h1dfab7ae32ff9c82, 64'h679dd514582f9fcf,
    64'h0f6d2b697bd44da8, 64'h77e36f7304c48942, 64'h3f9d85a86a1d36c8, 64'h1112e6ad91d692a1};

  function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (W - n));
  endfunction

  function automatic logic [W-1:0] bsig0(input logic [W-1:0] x);
    return rotr(x, BS0A) ^ rotr(x, BS0B) ^ rotr(x, BS0C);
  endfunction

  function automatic logic [W-1:0] bsig1(input logic [W-1:0] x);
    return rotr(x, BS1A) ^ rotr(x, BS1B) ^ rotr(x, BS1C);
  endfunction

  function automatic logic [W-1:0] ssig0(input logic [W-1:0] x);
    return rotr(x, SS0A) ^ rotr(x, SS0B) ^ (x >> SS0C);
  endfunction

  function automatic logic [W-1:0] ssig1(input logic [W-1:0] x);
    return rotr(x, SS1A) ^ rotr(x, SS1B) ^ (x >> SS1C);
  endfunction

  function automatic logic [W-1:0] iv_word(input logic [1:0] m, input logic [2:0] i);
    logic [63:0] v;
    case (m)
      2'd1:    v = IV384[i];
      2'd2:    v = IV512_256[i];
      2'd3:    v = IV512_224[i];
      default: v = IV512[i];
    endcase
    if (W == 32) v = (m == 2'd1) ? {32'h0, v[31:0]} : {32'h0, v[63:32]};
    return v[W-1:0];
  endfunction

  function automatic logic [W-1:0] keep_mask(input logic [1:0] m, input logic [2:0] i);
    logic [63:0] k;
    k = '1;
    if (W == 32) begin
      if (m == 2'd1 && i == 3'd7) k = '0;
    end else begin
      case (m)
        2'd1: if (i >= 3'd6) k = '0;
        2'd2: if (i >= 3'd4) k = '0;
        2'd3: begin
          if (i >= 3'd4) k = '0;
          else if (i == 3'd3) k = 64'hffffffff_00000000;
        end
        default: ;
      endcase
    end
    return k[W-1:0];
  endfunction

  typedef enum logic [2:0] {StIdle, StLoad, StExpand, StFinal, StOut} state_e;

  state_e               state_q, state_d;
  logic [1:0]           mode_q;
  logic                 last_q;
  logic [6:0]           round_q;
  logic [W-1:0]         work_q [8];
  logic [W-1:0]         chain_q [8];
  logic [W-1:0]         win_q [16];
  logic [8*W-1:0]       ctx_q, hash_q;
  logic                 ctx_valid_q, hash_valid_q, err_q;

  logic                 mode_rsvd, ctx_load_eff;
  logic [W-1:0]         w_exp, w_cur, k_cur, t1, t2;
  logic [W-1:0]         round_out [8];
  logic [W-1:0]         sum_w [8];
  logic [W-1:0]         init_w [8];
  logic [8*W-1:0]       sum_packed, digest;

  assign mode_rsvd    = (W == 32) && mode_i[1];
  assign ctx_load_eff = (CTX_EN != 0) && ctx_load_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start_i && !mode_rsvd) state_d = StLoad;
      StLoad:   if (data_valid_i && round_q == 7'd15) state_d = StExpand;
      StExpand: if (round_q == LastRound) state_d = StFinal;
      StFinal:  state_d = last_q ? StOut : StLoad;
      StOut:    if (hash_ready_i) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (abort_i && state_q != StIdle) state_d = StIdle;
  end

  always_comb begin
    data_ready_o = (state_q == StLoad);
    busy_o       = (state_q != StIdle);
  end

  always_comb begin
    w_exp = ssig1(win_q[14]) + win_q[9] + ssig0(win_q[1]) + win_q[0];
    w_cur = (state_q == StLoad) ? data_i : w_exp;
    k_cur = K64[round_q][63 -: W];
    t1 = work_q[7] + bsig1(work_q[4]) + ((work_q[4] & work_q[5]) ^ (~work_q[4] & work_q[6]))
       + k_cur + w_cur;
    t2 = bsig0(work_q[0])
       + ((work_q[0] & work_q[1]) ^ (work_q[0] & work_q[2]) ^ (work_q[1] & work_q[2]));
    round_out[0] = t1 + t2;
    round_out[1] = work_q[0];
    round_out[2] = work_q[1];
    round_out[3] = work_q[2];
    round_out[4] = work_q[3] + t1;
    round_out[5] = work_q[4];
    round_out[6] = work_q[5];
    round_out[7] = work_q[6];
    sum_packed = '0;
    digest     = '0;
    for (int i = 0; i < 8; i++) begin
      sum_w[i] = chain_q[i] + work_q[i];
      sum_packed[(7-i)*W +: W] = sum_w[i];
      digest[(7-i)*W +: W]     = sum_w[i] & keep_mask(mode_q, 3'(i));
      init_w[i] = ctx_load_eff ? ctx_i[(7-i)*W +: W] : iv_word(mode_i, 3'(i));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q       <= '0;
      last_q       <= 1'b0;
      round_q      <= '0;
      ctx_q        <= '0;
      hash_q       <= '0;
      ctx_valid_q  <= 1'b0;
      hash_valid_q <= 1'b0;
      err_q        <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        work_q[i]  <= '0;
        chain_q[i] <= '0;
      end
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
    end else begin
      err_q       <= 1'b0;
      ctx_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i && mode_rsvd) begin
            err_q <= 1'b1;
          end else if (start_i) begin
            mode_q  <= mode_i;
            work_q  <= init_w;
            chain_q <= init_w;
            last_q  <= 1'b0;
            round_q <= '0;
          end
        end
        StLoad: begin
          if (!abort_i && data_valid_i) begin
            work_q <= round_out;
            for (int i = 0; i < 15; i++) win_q[i] <= win_q[i+1];
            win_q[15] <= w_cur;
            round_q   <= round_q + 7'd1;
            if (last_i) last_q <= 1'b1;
          end
        end
        StExpand: begin
          if (!abort_i) begin
            work_q <= round_out;
            for (int i = 0; i < 15; i++) win_q[i] <= win_q[i+1];
            win_q[15] <= w_cur;
            round_q   <= (round_q == LastRound) ? 7'd0 : round_q + 7'd1;
          end
        end
        StFinal: begin
          if (!abort_i) begin
            chain_q     <= sum_w;
            ctx_q       <= sum_packed;
            ctx_valid_q <= 1'b1;
            if (last_q) begin
              hash_q       <= digest;
              hash_valid_q <= 1'b1;
            end else begin
              work_q <= sum_w;
            end
          end
        end
        StOut: if (abort_i || hash_ready_i) hash_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign ctx_o        = (CTX_EN != 0) ? ctx_q : '0;
  assign ctx_valid_o  = (CTX_EN != 0) && ctx_valid_q;
  assign hash_o       = hash_q;
  assign hash_valid_o = hash_valid_q;
  assign err_o        = err_q;

  round_in_range: assert property (@(posedge clk_i) disable iff (rst_i) round_q <= LastRound);

endmodule

// File: tb/tb_lw_sha2_ctx_core.sv
// Directed bench: SHA-256/224 on a 32-bit core and SHA-512, SHA-512/224 on a 64-bit core.
module tb_lw_sha2_ctx_core;

  localparam logic [255:0] H256_ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] H224_ABC = {224'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7, 32'h0};
  localparam logic [255:0] H256_2BLK = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [511:0] H512_ABC = {256'hddaf35a193617aba_cc417349ae204131_12e6fa4e89a97ea2_0a9eeee64b55d39a,
                                       256'h2192992a274fc1a8_36ba3c23a3feebbd_454d4423643ce80e_2a9ac94fa54ca49f};
  localparam logic [511:0] H512_224_ABC = {256'h4634270f707b6a54_daae7530460842e2_0e37ed265ceee9a4_3e8924aa00000000,
                                           256'h0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start, ctx_load, dvalid, dready, last, abort, busy, err, ctx_valid;
  logic         hash_valid, hash_ready;
  logic [1:0]   mode;
  logic [31:0]  data;
  logic [255:0] ctx_in, ctx_out, hash;

  logic         start64, dvalid64, dready64, last64, busy64, err64, ctx_valid64;
  logic         hash_valid64, hash_ready64;
  logic [1:0]   mode64;
  logic [63:0]  data64;
  logic [511:0] ctx_out64, hash64;

  lw_sha2_ctx_core #(.WORD_SIZE(32), .CTX_EN(1)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode), .ctx_load_i(ctx_load),
    .ctx_i(ctx_in), .data_valid_i(dvalid), .data_ready_o(dready), .data_i(data), .last_i(last),
    .abort_i(abort), .busy_o(busy), .err_o(err), .ctx_o(ctx_out), .ctx_valid_o(ctx_valid),
    .hash_o(hash), .hash_valid_o(hash_valid), .hash_ready_i(hash_ready)
  );

  lw_sha2_ctx_core #(.WORD_SIZE(64), .CTX_EN(1)) dut64 (
    .clk_i(clk), .rst_i(rst), .start_i(start64), .mode_i(mode64), .ctx_load_i(1'b0),
    .ctx_i('0), .data_valid_i(dvalid64), .data_ready_o(dready64), .data_i(data64),
    .last_i(last64), .abort_i(1'b0), .busy_o(busy64), .err_o(err64), .ctx_o(ctx_out64),
    .ctx_valid_o(ctx_valid64), .hash_o(hash64), .hash_valid_o(hash_valid64),
    .hash_ready_i(hash_ready64)
  );

  int ctx_pulses, hv_cycles, err_pulses;
  always @(negedge clk) begin
    if (ctx_valid)  ctx_pulses <= ctx_pulses + 1;
    if (hash_valid) hv_cycles  <= hv_cycles + 1;
    if (err)        err_pulses <= err_pulses + 1;
  end

  int n_vec, n_bad;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [31:0] blk_abc [16];
  logic [31:0] blk_m1 [16];
  logic [31:0] blk_m2 [16];

  task automatic send_word(input logic [31:0] w, input logic l);
    int guard;
    guard = 0;
    dvalid = 1'b1;
    data   = w;
    last   = l;
    while (!dready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!dready) check("ready_timeout", 512'(dready), 512'd1);
    @(negedge clk);
    dvalid = 1'b0;
    last   = 1'b0;
  endtask

  task automatic send_block(input logic [31:0] blk [16], input logic fin, input bit gappy);
    for (int i = 0; i < 16; i++) begin
      send_word(blk[i], fin && (i == 0));
      if (gappy && i != 15) @(negedge clk);
    end
  endtask

  task automatic start_msg(input logic [1:0] m, input logic cl, input logic [255:0] c);
    start    = 1'b1;
    mode     = m;
    ctx_load = cl;
    ctx_in   = c;
    @(negedge clk);
    start    = 1'b0;
    ctx_load = 1'b0;
  endtask

  task automatic wait_hash(output int n);
    n = 0;
    while (!hash_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic release_hash();
    hash_ready = 1'b1;
    @(negedge clk);
    hash_ready = 1'b0;
  endtask

  task automatic run_abc(input logic [1:0] m, input logic [255:0] exp, input string tag);
    int n;
    start_msg(m, 1'b0, '0);
    send_block(blk_abc, 1'b1, 1'b0);
    wait_hash(n);
    check({tag, "_latency"}, 512'(n), 512'd49);
    check({tag, "_hash"}, 512'(hash), 512'(exp));
  endtask

  task automatic run64(input logic [1:0] m, input logic [511:0] exp, input string tag);
    int n, guard;
    start64 = 1'b1;
    mode64  = m;
    @(negedge clk);
    start64 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      dvalid64 = 1'b1;
      data64   = (i == 0) ? 64'h6162638000000000 : ((i == 15) ? 64'h18 : 64'h0);
      last64   = (i == 0);
      guard = 0;
      while (!dready64 && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      @(negedge clk);
    end
    dvalid64 = 1'b0;
    last64   = 1'b0;
    n = 0;
    while (!hash_valid64 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 512'(n), 512'd65);
    check({tag, "_hash"}, hash64, exp);
    hash_ready64 = 1'b1;
    @(negedge clk);
    hash_ready64 = 1'b0;
    check({tag, "_release"}, {510'd0, hash_valid64, busy64}, 512'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, c0, h0, e0;
    logic [255:0] cap, saved;

    for (int i = 0; i < 16; i++) begin
      blk_abc[i] = 32'h0;
      blk_m2[i]  = 32'h0;
    end
    blk_abc[0]  = 32'h61626380;
    blk_abc[15] = 32'h00000018;
    blk_m2[15]  = 32'h000001c0;
    blk_m1 = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
               32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
               32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
               32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};

    rst = 1'b1; start = 1'b0; mode = 2'd0; ctx_load = 1'b0; ctx_in = '0;
    dvalid = 1'b0; data = '0; last = 1'b0; abort = 1'b0; hash_ready = 1'b0;
    start64 = 1'b0; mode64 = 2'd0; dvalid64 = 1'b0; data64 = '0; last64 = 1'b0;
    hash_ready64 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_ctrl", {507'd0, dready, busy, err, hash_valid, ctx_valid}, 512'd0);
    check("reset_hash", 512'(hash), 512'd0);
    check("reset_ctx", 512'(ctx_out), 512'd0);

    // SHA-256 "abc", digest held in OUT while start is (ignored) asserted
    #1 c0 = ctx_pulses;
    run_abc(2'd0, H256_ABC, "abc256");
    check("abc256_ctx_o", 512'(ctx_out), 512'(H256_ABC));
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    check("out_hold_valid", {510'd0, hash_valid, busy}, 512'd3);
    check("out_hold_hash", 512'(hash), 512'(H256_ABC));
    release_hash();
    check("out_release", {510'd0, hash_valid, busy}, 512'd0);
    #1 check("abc256_ctx_pulses", 512'(ctx_pulses - c0), 512'd1);

    // SHA-224 "abc" then a reserved mode
    run_abc(2'd1, H224_ABC, "abc224");
    check("abc224_ctx_untrunc", 512'(ctx_out[255:32]), 512'(H224_ABC[255:32]));
    release_hash();
    #1 e0 = err_pulses;
    start_msg(2'd2, 1'b0, '0);
    @(negedge clk);
    #1 check("rsvd_err_pulses", 512'(err_pulses - e0), 512'd1);
    check("rsvd_busy", 512'(busy), 512'd0);

    // Two-block message, gappy input, digest stalled for 10 cycles
    c0 = ctx_pulses;
    start_msg(2'd0, 1'b0, '0);
    send_block(blk_m1, 1'b0, 1'b1);
    send_block(blk_m2, 1'b1, 1'b1);
    wait_hash(n);
    check("two_blk_latency", 512'(n), 512'd49);
    cap = hash;
    repeat (10) @(negedge clk);
    check("two_blk_hold_valid", 512'(hash_valid), 512'd1);
    check("two_blk_stable", 512'(hash), 512'(cap));
    check("two_blk_hash", 512'(hash), 512'(H256_2BLK));
    release_hash();
    #1 check("two_blk_ctx_pulses", 512'(ctx_pulses - c0), 512'd2);

    // Save the chaining value after block 1, abort, resume from it
    start_msg(2'd0, 1'b0, '0);
    send_block(blk_m1, 1'b0, 1'b0);
    n = 0;
    while (!ctx_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    saved = ctx_out;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("ctx_abort_idle", {510'd0, busy, dready}, 512'd0);
    check("ctx_abort_keep", 512'(ctx_out), 512'(saved));
    start_msg(2'd0, 1'b1, saved);
    send_block(blk_m2, 1'b1, 1'b0);
    wait_hash(n);
    check("ctx_restore_hash", 512'(hash), 512'(H256_2BLK));
    release_hash();

    // Abort at round 30 of EXPAND
    #1 c0 = ctx_pulses;
    h0 = hv_cycles;
    start_msg(2'd0, 1'b0, '0);
    send_block(blk_abc, 1'b1, 1'b0);
    repeat (14) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("exp_abort_busy", 512'(busy), 512'd0);
    repeat (60) @(negedge clk);
    #1 check("exp_abort_no_hash", 512'(hv_cycles - h0), 512'd0);
    check("exp_abort_no_ctx", 512'(ctx_pulses - c0), 512'd0);
    run_abc(2'd0, H256_ABC, "after_abort");
    release_hash();

    // Reset at round 10 of LOAD
    start_msg(2'd0, 1'b0, '0);
    for (int i = 0; i < 10; i++) send_word(blk_abc[i], i == 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ctrl", {507'd0, dready, busy, err, hash_valid, ctx_valid}, 512'd0);
    check("midrst_hash", 512'(hash), 512'd0);
    check("midrst_ctx", 512'(ctx_out), 512'd0);
    run_abc(2'd0, H256_ABC, "after_rst");
    release_hash();

    // 64-bit family
    run64(2'd0, H512_ABC, "abc512");
    run64(2'd3, H512_224_ABC, "abc512_224");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lw_sha2_ctx_core.md
Name: lw_sha2_ctx_core

Overview:
- Parametrised word-serial SHA-2 compression core. One round per cycle; 16 message words are streamed in through a valid/ready handshake, and the 16-entry schedule window is expanded internally.
- Successor to the fixed lightweight SHA core. Adds:
  - WORD_SIZE selection (32-bit or 64-bit family),
  - context save/restore for split messages,
  - a per-block chaining-value output,
  - a held digest output with valid/ready backpressure.
- Sits between the message padder/DMA front-end and the register-file wrapper.

Parameters:
- WORD_SIZE, 32, word width.
  - 32 selects SHA-256/224; ROUNDS=64.
  - 64 selects SHA-512/384/512-256/512-224; ROUNDS=80.
  - Any other value is a configuration error and must fail elaboration.
- CTX_EN, 1, enables context save/restore. When 0: ctx_i is ignored, ctx_load_i is treated as 0, and ctx_o/ctx_valid_o are tied to 0.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- start_i  in  1  begin a message; sampled in IDLE only.
- mode_i  in  2  algorithm select, latched on start.
  - WORD_SIZE=32: 0=SHA-256, 1=SHA-224, 2/3 reserved.
  - WORD_SIZE=64: 0=SHA-512, 1=SHA-384, 2=SHA-512/256, 3=SHA-512/224.
- ctx_load_i  in  1  on start, use ctx_i instead of the standard IV.
- ctx_i  in  8*WORD_SIZE  saved chaining value; H0 in the MSBs.
- data_valid_i  in  1  message word valid.
- data_ready_o  out  1  core accepts a word.
- data_i  in  WORD_SIZE  message word, big-endian.
- last_i  in  1  current block is the final block; qualified by a data accept.
- abort_i  in  1  cancel the current operation.
- busy_o  out  1  state != IDLE.
- err_o  out  1  one-cycle pulse on start with a reserved mode.
- ctx_o  out  8*WORD_SIZE  chaining value after the latest block, untruncated.
- ctx_valid_o  out  1  one-cycle pulse when ctx_o updates.
- hash_o  out  8*WORD_SIZE  final digest; H0 in the MSBs.
- hash_valid_o  out  1  digest valid; held until accepted.
- hash_ready_i  in  1  digest accepted.

Behaviour:
- Reset: state=IDLE. All outputs are 0, including data_ready_o, busy_o, err_o, hash_o, hash_valid_o, ctx_o and ctx_valid_o.
- FSM states: IDLE, LOAD, EXPAND, FINAL, OUT.
- IDLE:
  - start_i with a valid mode: latch the mode; load working state and chaining register from the IV (or from ctx_i if ctx_load_i); clear the last flag; go to LOAD.
  - start_i with a reserved mode: err_o pulses for 1 cycle and the state stays IDLE.
- LOAD:
  - data_ready_o=1.
  - Each accept (valid&&ready) performs round r (r=0..15) on data_i, writes the schedule window, and increments r.
  - No accept means no state change; stalls of any length are allowed.
  - A last_i sampled with any accepted word sets the sticky last flag for this block.
  - After the accept at r=15, go to EXPAND.
- EXPAND:
  - One round per cycle on the expanded word, r=16..ROUNDS-1.
  - data_ready_o=0.
  - Then go to FINAL.
- FINAL (1 cycle):
  - chain[i] += working[i], modulo 2^WORD_SIZE.
  - ctx_o gets the new chain value; ctx_valid_o pulses; this happens for every block, including the last.
  - If the last flag is clear: working = new chain, r=0, go to LOAD.
  - If the last flag is set: register the truncated digest into hash_o, assert hash_valid_o, go to OUT.
- Latency: hash_valid_o rises ROUNDS-15 cycles after the edge accepting word 15 of the final block. That is 49 cycles for SHA-256 and 65 for SHA-512. Zero-stall block period is ROUNDS+1 cycles.
- OUT:
  - hash_o and hash_valid_o are held stable until hash_ready_i=1.
  - On hash_ready_i=1: hash_valid_o drops on the next edge and the state returns to IDLE.
  - start_i is ignored in OUT; it is accepted from IDLE on the following cycle.
- Truncation in hash_o (word index 0 = MSBs); unused words are forced to 0:
  - SHA-224: H7=0.
  - SHA-384: H6 and H7=0.
  - SHA-512/256: H4..H7=0.
  - SHA-512/224: H3 low half and H4..H7=0.
- abort_i in LOAD/EXPAND/FINAL/OUT:
  - Next state is IDLE; hash_valid_o and data_ready_o drop next cycle.
  - The FINAL update is suppressed (no ctx_valid_o pulse).
  - ctx_o keeps its last published value.
- abort_i in IDLE has no effect. start_i and abort_i together in IDLE means the start wins.
- rst_i mid-operation: full reset on the next edge, regardless of state.
- A round counter wrap past ROUNDS-1 is impossible by construction and is checked by assertion.

Test Plan:
- SHA-256 "abc": words 61626380, fourteen 0s, 00000018, last_i on word 0 -> hash_o=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad. hash_valid_o asserted exactly 49 cycles after word 15 is accepted; one ctx_valid_o pulse.
- SHA-224 "abc" with mode=1 -> 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7, and H7=0. Separately, start with mode=2 -> one err_o pulse and busy_o stays 0.
- Two-block SHA-256 "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":
  - Run with data_valid_i toggling every other cycle and hash_ready_i held low for 10 cycles.
  - Required: hash_o=248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1, held stable while stalled; exactly two ctx_valid_o pulses.
- Context restore on the same message:
  - Save ctx_o after block 1, then abort.
  - Restart with ctx_load_i=1, ctx_i=saved, and feed block 2 only.
  - Required: the identical digest.
- Abort at r=30 of EXPAND -> busy_o=0 next cycle, no hash_valid_o, no ctx_valid_o. Likewise, rst_i at r=10 of LOAD -> all outputs 0. In both cases a following SHA-256 "abc" run produces the correct digest.
- WORD_SIZE=64:
  - SHA-512 "abc" -> ddaf35a193617aba cc417349ae204131 12e6fa4e89a97ea2 0a9eeee64b55d39a 2192992a274fc1a8 36ba3c23a3feebbd 454d4423643ce80e 2a9ac94fa54ca49f.
  - mode=3 -> 4634270f707b6a54 daae7530460842e2 0e37ed265ceee9a4 3e8924aa00000000, followed by zeros in H4..H7.
